fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter WAIT_MAX, default 15, SHALL be the maximum number of cycles spent waiting on imem_ready before a fault.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 imem_req  out  1  SHALL be the instruction-memory read request.
REQ-006 imem_addr  out  32  SHALL be the fetch address, equal to pc whenever imem_req=1.
REQ-007 imem_ready  in  1  SHALL indicate imem_rdata is valid this cycle.
REQ-008 imem_rdata  in  32  SHALL be the instruction word from memory.
REQ-009 instr  out  32  SHALL be the latched instruction presented to the datapath.
REQ-010 instr_valid  out  1  SHALL be a one-cycle execute strobe for instr.
REQ-011 pc  out  32  SHALL be the current program counter.
REQ-012 pc_branch  in  32  SHALL be the branch target from the datapath (pc+4 + SignImm<<2).
REQ-013 branch, zero, jump  in  1 each  SHALL be the control/ALU flags, sampled only when instr_valid=1.
REQ-014 halt_req  in  1  SHALL request stop, sampled only when instr_valid=1.
REQ-015 retired  out  32  SHALL count executed instructions.
REQ-016 halted, fault  out  1 each  SHALL flag the HALT and FAULT states.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, EXEC, HALT, FAULT.
REQ-018 IDLE SHALL last one cycle after reset deassertion, then go to FETCH.
REQ-019 FETCH SHALL drive imem_req=1; on imem_ready=1 it SHALL latch imem_rdata into instr and go to EXEC next cycle.
REQ-020 FETCH SHALL count consecutive cycles with imem_ready=0 in a wait counter; when the counter equals WAIT_MAX with imem_ready=0, the FSM SHALL go to FAULT.
REQ-021 The wait counter SHALL clear on every entry to FETCH; imem_ready in the WAIT_MAX-th cycle SHALL still complete the fetch normally.
REQ-022 EXEC SHALL last exactly one cycle with instr_valid=1 and imem_req=0.
REQ-023 In EXEC the next pc SHALL be selected with priority jump > (branch & zero) > pc+4.
REQ-024 The jump target SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}, where pc_plus4 = pc + 4 computed internally, modulo 2^32.
REQ-025 pc+4 SHALL wrap: pc=32'hFFFF_FFFC yields 32'h0000_0000 with no fault.
REQ-026 In EXEC retired SHALL increment by 1 modulo 2^32.
REQ-027 After EXEC the FSM SHALL go to HALT if halt_req=1 (pc still updated, instruction counted), else to FETCH.
REQ-028 If the selected next pc has bits [1:0] != 2'b00, the FSM SHALL go to FAULT, pc SHALL keep its old value, and retired SHALL still increment; fault takes priority over halt_req.
REQ-029 HALT and FAULT SHALL be terminal until reset; imem_req=0, instr_valid=0, pc and retired frozen.
REQ-030 halted=1 exactly in HALT and fault=1 exactly in FAULT.
REQ-031 Flag inputs outside EXEC SHALL have no effect.

Reset
REQ-032 On a clock edge with reset=1 the block SHALL enter IDLE with pc=RESET_PC, instr=0, retired=0, wait counter=0, imem_req=0, instr_valid=0, halted=0, fault=0.
REQ-033 Reset SHALL take priority in every state, including mid-FETCH with imem_ready=1 and in HALT/FAULT; the pending fetch data SHALL be discarded.

Verification
REQ-034 Reset, imem_ready held 1, all flags 0 -> imem_addr sequence 0,4,8,12, one fetch every 2 cycles after IDLE; retired=4 after the 4th EXEC.
REQ-035 pc=0x100, branch=1, zero=1, pc_branch=0x200 in EXEC -> next imem_addr=0x200; with zero=0 -> 0x104; with jump=1 and instr[25:0]=26'h40 as well -> 0x100.
REQ-036 imem_ready low for 14 cycles, high on the 15th (WAIT_MAX=15) -> normal EXEC; low for 15 cycles -> fault=1, imem_req=0, pc unchanged.
REQ-037 halt_req=1 in EXEC at pc=0x8 -> halted=1, pc=0xC, retired incremented, no further requests; reset -> pc=RESET_PC, halted=0.
REQ-038 branch=1, zero=1, pc_branch=0x102 -> fault=1, pc stays at old value; pc=0xFFFF_FFFC with flags 0 -> next pc 0x0, fault=0.
REQ-039 reset asserted in FETCH cycle with imem_ready=1 -> instr=0, instr_valid never pulses, IDLE next cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer -- instruction fetch/execute sequencer.
//
// Fetches one instruction word from instruction memory, presents it to the
// datapath for a single execute cycle, then computes the next pc (jump,
// taken branch or pc+4). A fetch that waits too long on memory, or a next pc
// that is not word aligned, parks the block in FAULT. A halt request seen in
// the execute cycle parks it in HALT. Both are left only through reset.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   synchronous active-high reset
//   imem_req     out  instruction-memory read request (FETCH only)
//   imem_addr    out  fetch address (always the current pc)
//   imem_ready   in   imem_rdata valid this cycle
//   imem_rdata   in   instruction word from memory
//   instr        out  latched instruction for the datapath
//   instr_valid  out  one-cycle execute strobe (EXEC only)
//   pc           out  current program counter
//   pc_branch    in   branch target from the datapath
//   branch       in   branch instruction flag   (sampled in EXEC)
//   zero         in   ALU zero flag             (sampled in EXEC)
//   jump         in   jump instruction flag     (sampled in EXEC)
//   halt_req     in   stop request              (sampled in EXEC)
//   retired      out  executed-instruction count, wraps at 2^32
//   halted       out  high in HALT
//   fault        out  high in FAULT
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | one cycle after reset release
// FETCH | imem_req high, waiting for imem_ready (bounded by WAIT_MAX)
// EXEC  | instr_valid high for one cycle, next pc and retire count update
// HALT  | stopped on request, everything frozen until reset
// FAULT | fetch timeout or misaligned next pc, frozen until reset

module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  input  logic [31:0] pc_branch,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        halt_req,
  output logic [31:0] retired,
  output logic        halted,
  output logic        fault
);

  localparam int unsigned WW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     retired_q, retired_d;
  logic [WW-1:0]   wait_q, wait_d;

  logic [31:0]     pc_plus4;
  logic [31:0]     jump_tgt;
  logic [31:0]     pc_sel;
  logic [WW-1:0]   wait_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    // Counter only survives while FETCH keeps waiting, so every new entry
    // into FETCH starts from zero.
    wait_d    = '0;

    pc_plus4 = pc_q + 32'd4;
    jump_tgt = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    if (jump) begin
      pc_sel = jump_tgt;
    end else if (branch && zero) begin
      pc_sel = pc_branch;
    end else begin
      pc_sel = pc_plus4;
    end

    // wait_inc is the number of not-ready cycles including this one.
    wait_inc = wait_q + WW'(1);

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end else if (wait_inc == WW'(WAIT_MAX)) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_EXEC: begin
        retired_d = retired_q + 32'd1;
        // A misaligned target faults before halt_req is considered and
        // leaves pc pointing at the instruction that produced it.
        if (pc_sel[1:0] != 2'b00) begin
          state_d = S_FAULT;
        end else begin
          pc_d    = pc_sel;
          state_d = halt_req ? S_HALT : S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_EXEC);
  assign pc          = pc_q;
  assign retired     = retired_q;
  assign halted      = (state_q == S_HALT);
  assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer. The bench plays instruction memory and the
// datapath. Each instruction is one transaction: a chosen number of
// not-ready cycles, an instruction word, and the flags presented during the
// execute strobe. The reference model tracks pc, retire count and whether
// the block is running, halted or faulted, using the architectural rules
// (pc+4, jump target, taken branch, alignment, timeout).

module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          WAIT_MAX = 15;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_branch;
  logic        branch;
  logic        zero;
  logic        jump;
  logic        halt_req;
  logic [31:0] retired;
  logic        halted;
  logic        fault;

  fetch_sequencer #(
    .RESET_PC (RESET_PC),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_branch   (pc_branch),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .halt_req    (halt_req),
    .retired     (retired),
    .halted      (halted),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: 0 running, 1 halted, 2 faulted.
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  int          m_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Flags outside EXEC must be ignored, so keep them noisy there.
  task automatic noise_flags();
    branch    = 1'($urandom);
    zero      = 1'($urandom);
    jump      = 1'($urandom);
    halt_req  = 1'($urandom);
    pc_branch = $urandom;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_pc"},      pc,                       m_pc);
    chk({tag, "_retired"}, retired,                  m_ret);
    chk({tag, "_halted"},  32'(halted),              32'(m_mode == 1));
    chk({tag, "_fault"},   32'(fault),               32'(m_mode == 2));
    chk({tag, "_req"},     32'(imem_req),            32'(m_mode == 0));
    chk({tag, "_iv"},      32'(instr_valid),         32'd0);
  endtask

  task automatic check_frozen(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      noise_flags();
      @(negedge clk);
      chk_status("frozen");
    end
  endtask

  // Ends at the negedge where the block is in FETCH.
  task automatic do_reset();
    reset      = 1'b1;
    imem_ready = 1'($urandom);
    imem_rdata = $urandom;
    noise_flags();
    @(negedge clk);
    @(negedge clk);
    m_pc   = RESET_PC;
    m_ret  = 32'd0;
    m_mode = 0;
    chk("rst_pc",      pc,                RESET_PC);
    chk("rst_instr",   instr,             32'd0);
    chk("rst_retired", retired,           32'd0);
    chk("rst_req",     32'(imem_req),     32'd0);
    chk("rst_iv",      32'(instr_valid),  32'd0);
    chk("rst_halted",  32'(halted),       32'd0);
    chk("rst_fault",   32'(fault),        32'd0);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_instr(input int delay, input logic [31:0] word,
                          input logic br, input logic zr, input logic jp,
                          input logic hr, input logic [31:0] pbr);
    int          n_low;
    logic [31:0] p4;
    logic [31:0] tgt;
    if (m_mode != 0) return;
    n_low = (delay < WAIT_MAX) ? delay : WAIT_MAX;
    for (int i = 0; i < n_low; i++) begin
      chk("fetch_req",  32'(imem_req),    32'd1);
      chk("fetch_addr", imem_addr,        m_pc);
      chk("fetch_iv",   32'(instr_valid), 32'd0);
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      noise_flags();
      @(negedge clk);
    end
    if (delay >= WAIT_MAX) begin
      m_mode = 2;
      chk_status("timeout");
      return;
    end
    chk("fetch_req",  32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr,     m_pc);
    imem_ready = 1'b1;
    imem_rdata = word;
    noise_flags();
    @(negedge clk);

    chk("exec_iv",    32'(instr_valid), 32'd1);
    chk("exec_instr", instr,            word);
    chk("exec_req",   32'(imem_req),    32'd0);
    chk("exec_pc",    pc,               m_pc);
    branch     = br;
    zero       = zr;
    jump       = jp;
    halt_req   = hr;
    pc_branch  = pbr;
    imem_ready = 1'($urandom);
    imem_rdata = $urandom;
    @(negedge clk);

    p4 = m_pc + 32'd4;
    if (jp)             tgt = {p4[31:28], word[25:0], 2'b00};
    else if (br && zr)  tgt = pbr;
    else                tgt = p4;
    m_ret = m_ret + 32'd1;
    if (tgt[1:0] != 2'b00) begin
      m_mode = 2;
    end else begin
      m_pc = tgt;
      if (hr) m_mode = 1;
    end
    chk_status("post_exec");
    branch   = 1'b0;
    zero     = 1'b0;
    jump     = 1'b0;
    halt_req = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    branch     = 1'b0;
    zero       = 1'b0;
    jump       = 1'b0;
    halt_req   = 1'b0;
    pc_branch  = 32'd0;
    m_pc       = RESET_PC;
    m_ret      = 32'd0;
    m_mode     = 0;

    // Straight-line fetch, memory always ready.
    do_reset();
    chk("seq_addr0", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      do_instr(0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, $urandom);
      if (i < 3) chk("seq_addr", imem_addr, 32'(4 * (i + 1)));
    end
    chk("seq_retired4", retired, 32'd4);

    // Branch / jump selection from pc=0x100.
    do_instr(0, 32'h0000_0040, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("jmp_to_100", imem_addr, 32'h100);
    do_instr(0, $urandom, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200);
    chk("br_taken", imem_addr, 32'h200);
    do_instr(0, 32'h0000_0040, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    do_instr(0, $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 32'h200);
    chk("br_not_taken", imem_addr, 32'h104);
    do_instr(0, 32'h0000_0040, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    do_instr(0, 32'h0000_0040, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200);
    chk("jump_over_branch", imem_addr, 32'h100);

    // Wait limit: 14 low then ready completes, 15 low faults.
    do_instr(WAIT_MAX - 1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wait14_ok", imem_addr, 32'h104);
    do_instr(WAIT_MAX, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wait15_fault", 32'(fault), 32'd1);
    chk("wait15_pc", pc, 32'h104);
    check_frozen(4);

    // Halt at pc=0x8.
    do_reset();
    do_instr(0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_instr(0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    do_instr(0, $urandom, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", pc, 32'hC);
    chk("halt_retired", retired, 32'd3);
    check_frozen(5);
    do_reset();
    chk("after_halt_pc", pc, RESET_PC);
    chk("after_halt_halted", 32'(halted), 32'd0);

    // Misaligned branch target faults and keeps pc; beats halt_req.
    do_instr(0, 32'h0000_0040, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    do_instr(0, $urandom, 1'b1, 1'b1, 1'b0, 1'b1, 32'h102);
    chk("misalign_fault", 32'(fault), 32'd1);
    chk("misalign_halted", 32'(halted), 32'd0);
    chk("misalign_pc", pc, 32'h100);
    chk("misalign_retired", retired, 32'd2);
    check_frozen(3);

    // pc+4 wraps from the top of the address space.
    do_reset();
    do_instr(0, $urandom, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    chk("top_pc", pc, 32'hFFFF_FFFC);
    do_instr(0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_fault", 32'(fault), 32'd0);

    // Reset during a completing fetch discards the data.
    do_instr(0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("pre_rst_instr", instr, 32'h1234_5678);
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("midrst_instr", instr, 32'd0);
    chk("midrst_iv", 32'(instr_valid), 32'd0);
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_pc", pc, RESET_PC);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_refetch", 32'(imem_req), 32'd1);
    chk("midrst_iv2", 32'(instr_valid), 32'd0);
    chk("midrst_instr2", instr, 32'd0);
    m_pc   = RESET_PC;
    m_ret  = 32'd0;
    m_mode = 0;
    do_instr(0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Randomized programs.
    for (int r = 0; r < 25; r++) begin
      do_reset();
      for (int k = 0; k < 25; k++) begin
        int          dly;
        logic [31:0] pbr;
        logic [31:0] w;
        if (m_mode != 0) break;
        if ($urandom_range(0, 15) == 0)     dly = WAIT_MAX;
        else if ($urandom_range(0, 2) == 0) dly = $urandom_range(0, WAIT_MAX - 1);
        else                                dly = 0;
        w   = $urandom;
        pbr = $urandom;
        if ($urandom_range(0, 7) != 0) pbr[1:0] = 2'b00;
        do_instr(dly, w, 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0), pbr);
      end
      if (m_mode != 0) check_frozen(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
